// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: width helpers and parameter legality check for sync_fifo_thresh.
package sync_fifo_pkg;
  function automatic int fifo_aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction
  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic bit fifo_params_ok(input int depth, input int af, input int ae);
    return (depth >= 2) && (ae >= 0) && (ae < af) && (af <= depth);
  endfunction
endpackage

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p: DEPTH x DW storage, one synchronous write port, one asynchronous read port.
module fifo_ram_2p #(
  parameter int DEPTH = 24,
  parameter int DW    = 8,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/sync_fifo_thresh.sv
// sync_fifo_thresh: single-clock FIFO with count, almost flags, sticky errors and flush.
// Define SYNC_FIFO_THRESH_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_thresh
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH    = 24,
  parameter int DW       = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CW      = fifo_cw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic          wren,
  input  logic [DW-1:0] datain,
  input  logic          rden,
  output logic [DW-1:0] dataout,
  output logic          dout_vld,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);
  localparam int AW = fifo_aw(DEPTH);
  if (!fifo_params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_thresh: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          wr_ok, rd_ok;
  logic [DW-1:0] rd_data;
  assign full         = count_q == CW'(DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= CW'(AF_LEVEL);
  assign almost_empty = count_q <= CW'(AE_LEVEL);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign wr_ok        = wren && !full && !clr;
  assign rd_ok        = rden && !empty && !clr;
  // Pointers wrap explicitly at DEPTH-1 since DEPTH need not be a power of two.
  always_comb begin
    wr_ptr_d = clr ? '0 : !wr_ok ? wr_ptr_q : (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    rd_ptr_d = clr ? '0 : !rd_ok ? rd_ptr_q : (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    count_d  = clr ? '0 : (wr_ok && !rd_ok) ? count_q + CW'(1) : (rd_ok && !wr_ok) ? count_q - CW'(1) : count_q;
    ovf_d    = !clr && (ovf_q || (wren && full));
    unf_d    = !clr && (unf_q || (rden && empty));
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  fifo_ram_2p #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_ram (
    .clk (clk),
    .we  (wr_ok),
    .wa  (wr_ptr_q),
    .wd  (datain),
    .ra  (rd_ptr_q),
    .rd  (rd_data)
  );
`ifdef SYNC_FIFO_THRESH_FWFT_EN
  assign dataout  = rd_data;
  assign dout_vld = !empty;
`else
  logic [DW-1:0] dout_q, dout_d;
  logic          vld_q, vld_d;
  always_comb begin
    dout_d = rd_ok ? rd_data : dout_q;
    vld_d  = rd_ok;
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  assign dataout  = dout_q;
  assign dout_vld = vld_q;
`endif
endmodule

// File: tb/tb_sync_fifo_thresh.sv
// tb_sync_fifo_thresh: directed checks of sync_fifo_thresh (DEPTH=24, DW=8), both read modes.
module tb_sync_fifo_thresh;
  localparam int DEPTH = 24;
  logic       clk = 0, rst_b = 0, clr = 0, wren = 0, rden = 0;
  logic [7:0] datain = '0;
  logic [7:0] dataout;
  logic [4:0] count;
  logic       dout_vld, full, empty, almost_full, almost_empty, overflow, underflow;
  int         n_chk = 0, n_pass = 0, n_fail = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;
  bit         wok, rok;

  sync_fifo_thresh dut (
    .clk(clk), .rst_b(rst_b), .clr(clr), .wren(wren), .datain(datain), .rden(rden),
    .dataout(dataout), .dout_vld(dout_vld), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_ae"}, 32'(almost_empty), 1);
    chk({tag, "_af"}, 32'(almost_full), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_unf"}, 32'(underflow), 0);
    chk({tag, "_vld"}, 32'(dout_vld), 0);
`ifndef SYNC_FIFO_THRESH_FWFT_EN
    chk({tag, "_dout"}, 32'(dataout), 0);
`endif
  endtask

  initial begin
    #2 chk_reset("rst");
    #10 rst_b = 1;
    step();
    // fill to full, then one write too many
    for (int i = 1; i <= DEPTH; i++) begin
      wren = 1; datain = i[7:0];
      step();
      chk("t1_count", 32'(count), i);
      chk("t1_full", 32'(full), 32'(i == DEPTH));
      chk("t1_af", 32'(almost_full), 32'(i >= 22));
      chk("t1_ae", 32'(almost_empty), 32'(i <= 2));
    end
    datain = 8'hFF;
    step();
    wren = 0;
    chk("t1_ovf", 32'(overflow), 1);
    chk("t1_count_full", 32'(count), DEPTH);
    // drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      rden = 1;
`ifdef SYNC_FIFO_THRESH_FWFT_EN
      chk("t2_data", 32'(dataout), i);
      chk("t2_vld", 32'(dout_vld), 1);
`endif
      step();
`ifndef SYNC_FIFO_THRESH_FWFT_EN
      chk("t2_data", 32'(dataout), i);
      chk("t2_vld", 32'(dout_vld), 1);
`endif
      chk("t2_count", 32'(count), DEPTH - i);
    end
    rden = 0;
    step();
    chk("t2_vld_idle", 32'(dout_vld), 0);
    chk("t2_empty", 32'(empty), 1);
`ifndef SYNC_FIFO_THRESH_FWFT_EN
    chk("t2_hold", 32'(dataout), 8'h18);
`endif
    rden = 1;
    step();
    rden = 0;
    chk("t2_unf", 32'(underflow), 1);
    chk("t2_count0", 32'(count), 0);
    chk("t2_ovf_sticky", 32'(overflow), 1);
    clr = 1;
    step();
    clr = 0;
    chk("t2_clr_ovf", 32'(overflow), 0);
    chk("t2_clr_unf", 32'(underflow), 0);
    // simultaneous read/write at mid, full and empty
    for (int i = 1; i <= 10; i++) begin
      wren = 1; datain = 8'h30 + i[7:0];
      step();
    end
    rden = 1; datain = 8'h40;
`ifdef SYNC_FIFO_THRESH_FWFT_EN
    chk("t4_mid_head", 32'(dataout), 8'h31);
`endif
    step();
    wren = 0; rden = 0;
    chk("t4_mid_count", 32'(count), 10);
`ifndef SYNC_FIFO_THRESH_FWFT_EN
    chk("t4_mid_data", 32'(dataout), 8'h31);
`endif
    for (int i = 0; i < 14; i++) begin
      wren = 1; datain = 8'h50 + i[7:0];
      step();
    end
    chk("t4_full", 32'(full), 1);
    rden = 1; datain = 8'h99;
    step();
    wren = 0; rden = 0;
    chk("t4_full_count", 32'(count), 23);
    chk("t4_full_ovf", 32'(overflow), 1);
`ifndef SYNC_FIFO_THRESH_FWFT_EN
    chk("t4_full_data", 32'(dataout), 8'h32);
`endif
    clr = 1;
    step();
    clr = 0;
    chk("t4_clr_count", 32'(count), 0);
    wren = 1; rden = 1; datain = 8'h77;
    step();
    wren = 0; rden = 0;
    chk("t4_empty_count", 32'(count), 1);
    chk("t4_empty_unf", 32'(underflow), 1);
`ifdef SYNC_FIFO_THRESH_FWFT_EN
    chk("t4_empty_vld", 32'(dout_vld), 1);
    chk("t4_empty_head", 32'(dataout), 8'h77);
`else
    chk("t4_empty_vld", 32'(dout_vld), 0);
`endif
    rden = 1;
    step();
    rden = 0;
`ifndef SYNC_FIFO_THRESH_FWFT_EN
    chk("t4_empty_data", 32'(dataout), 8'h77);
`endif
    chk("t4_drained", 32'(count), 0);
    clr = 1;
    step();
    clr = 0;
    // flush beats a same-cycle write
    for (int i = 0; i < 15; i++) begin
      wren = 1; datain = 8'h60 + i[7:0];
      step();
    end
    chk("t5_count15", 32'(count), 15);
    clr = 1; datain = 8'hEE;
    step();
    clr = 0; wren = 0;
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_ae", 32'(almost_empty), 1);
    chk("t5_af", 32'(almost_full), 0);
    chk("t5_vld", 32'(dout_vld), 0);
    wren = 1; datain = 8'hA5;
    step();
    wren = 0; rden = 1;
`ifdef SYNC_FIFO_THRESH_FWFT_EN
    chk("t5_a5", 32'(dataout), 8'hA5);
`endif
    step();
    rden = 0;
`ifndef SYNC_FIFO_THRESH_FWFT_EN
    chk("t5_a5", 32'(dataout), 8'hA5);
`endif
    chk("t5_empty2", 32'(empty), 1);
    // random traffic against a queue model
    q.delete();
    for (int c = 0; c < 300; c++) begin
      wren = 1'($urandom_range(0, 1));
      rden = 1'($urandom_range(0, 1));
      datain = 8'($urandom);
      wok = wren && q.size() < DEPTH;
      rok = rden && q.size() > 0;
`ifdef SYNC_FIFO_THRESH_FWFT_EN
      chk("t3_vld", 32'(dout_vld), 32'(q.size() > 0));
      if (q.size() > 0) chk("t3_head", 32'(dataout), 32'(q[0]));
`endif
      step();
      if (rok) exp_d = q.pop_front();
      if (wok) q.push_back(datain);
`ifndef SYNC_FIFO_THRESH_FWFT_EN
      chk("t3_vld", 32'(dout_vld), 32'(rok));
      if (rok) chk("t3_data", 32'(dataout), 32'(exp_d));
`endif
      chk("t3_count", 32'(count), q.size());
    end
    wren = 0; rden = 0; clr = 1;
    step();
    clr = 0;
    // asynchronous reset in the middle of a burst
    for (int i = 0; i < 8; i++) begin
      wren = 1; datain = 8'h81 + i[7:0];
      step();
    end
    wren = 0; rden = 1;
    step();
    rden = 0;
    chk("t6_count7", 32'(count), 7);
    wren = 1; datain = 8'hC0;
    #2 rst_b = 0;
    #1 chk_reset("t6");
    wren = 0;
    #2 rst_b = 1;
    step();
    chk("t6_after_count", 32'(count), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
